// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the byte-wide SPI master.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W      = 8;
    localparam int unsigned HALF_PERIOD_DEF = 2;
    localparam int unsigned DIV_W           = 8;
    localparam int unsigned BIT_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GUARD
    } spi_state_e;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period divider: one-cycle tick every HALF_PERIOD clks, restartable by clear.
module spi_sclk_tick
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_c
);

    logic [DIV_W-1:0] cnt;

    assign tick_c = (cnt == DIV_W'(HALF_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst || clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Mode-0 SPI master: one full-duplex MSB-first byte per request, framed by cs_n
// with a guard gap before the next frame.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SPI_BYTE_W-1:0] spi_data_in,
    input  logic                  spi_ready_send,
    output logic [SPI_BYTE_W-1:0] spi_data_out,
    output logic                  spi_busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    spi_state_e            state;
    logic [SPI_BYTE_W-2:0] tx;
    logic [SPI_BYTE_W-1:0] rx;
    logic [BIT_W-1:0]      bit_idx;
    logic                  tick_c;
    logic                  div_clear_c;

    // Divider is held at zero while idle so the first half-period is full length.
    assign div_clear_c = (state == ST_IDLE);

    spi_sclk_tick #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (div_clear_c),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            spi_busy     <= 1'b0;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            spi_data_out <= '0;
            tx           <= '0;
            rx           <= '0;
            bit_idx      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (spi_ready_send) begin
                        // MSB goes straight to mosi; tx keeps only the remaining bits.
                        tx       <= spi_data_in[SPI_BYTE_W-2:0];
                        mosi     <= spi_data_in[SPI_BYTE_W-1];
                        spi_busy <= 1'b1;
                        cs_n     <= 1'b0;
                        bit_idx  <= '0;
                        state    <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (tick_c) begin
                        sclk  <= 1'b1;
                        rx    <= {rx[SPI_BYTE_W-2:0], miso};
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick_c) begin
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_idx != BIT_W'(SPI_BYTE_W - 1)) begin
                                mosi    <= tx[SPI_BYTE_W-2];
                                tx      <= {tx[SPI_BYTE_W-3:0], 1'b0};
                                bit_idx <= bit_idx + BIT_W'(1);
                            end else begin
                                state <= ST_TRAIL;
                            end
                        end else begin
                            sclk <= 1'b1;
                            rx   <= {rx[SPI_BYTE_W-2:0], miso};
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick_c) begin
                        cs_n         <= 1'b1;
                        mosi         <= 1'b0;
                        spi_data_out <= rx;
                        state        <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (tick_c) begin
                        spi_busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed and randomized checks of spi_master_core against a byte-level SPI model.
module tb_spi_master_core;

    localparam int unsigned HP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spi_data_in;
    logic       spi_ready_send;
    logic [7:0] spi_data_out;
    logic       spi_busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    int compared   = 0;
    int mismatched = 0;

    // Monotone event counters; the stimulus takes snapshots and checks deltas.
    int          rises      = 0;
    int          falls      = 0;
    int          cs_falls   = 0;
    int          busy_total = 0;
    int          mosi_zero  = 0;
    logic [31:0] mosi_hist  = '0;

    // Slave model: presents slave_byte MSB first, advancing on each sclk fall.
    logic [7:0] slave_byte = 8'h00;
    bit         loopback   = 1'b1;
    int         fall_base  = 0;

    spi_master_core #(.HALF_PERIOD(HP)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_data_in    (spi_data_in),
        .spi_ready_send (spi_ready_send),
        .spi_data_out   (spi_data_out),
        .spi_busy       (spi_busy),
        .sclk           (sclk),
        .mosi           (mosi),
        .miso           (miso),
        .cs_n           (cs_n)
    );

    always #5 clk = ~clk;

    always_comb begin
        int idx;
        idx = falls - fall_base;
        if (loopback)
            miso = mosi;
        else if (idx >= 0 && idx <= 7)
            miso = slave_byte[7 - idx];
        else
            miso = 1'b0;
    end

    always @(posedge sclk) begin
        rises     <= rises + 1;
        mosi_hist <= {mosi_hist[30:0], mosi};
    end

    always @(negedge sclk) falls <= falls + 1;

    always @(negedge cs_n) cs_falls <= cs_falls + 1;

    always @(negedge clk) begin
        if (spi_busy === 1'b1) busy_total <= busy_total + 1;
        if (cs_n === 1'b0 && mosi === 1'b0) mosi_zero <= mosi_zero + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string tag);
        int n;
        n = 0;
        while (spi_busy !== lvl && n < lim) begin
            step();
            n++;
        end
        check(tag, 32'(spi_busy), 32'(lvl));
    endtask

    // One connector-style transfer: request held until busy, then dropped.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input bit lb, input string tag);
        int r0, b0, c0;
        r0 = rises; b0 = busy_total; c0 = cs_falls;
        fall_base = falls;
        slave_byte = sb;
        loopback = lb;
        spi_data_in = tx;
        spi_ready_send = 1'b1;
        wait_busy(1'b1, 10, {tag, "_busy_rise"});
        spi_ready_send = 1'b0;
        wait_busy(1'b0, 40 * HP + 20, {tag, "_busy_fall"});
        check({tag, "_mosi_bits"}, 32'(mosi_hist[7:0]), 32'(tx));
        check({tag, "_rises"}, 32'(rises - r0), 32'd8);
        check({tag, "_busy_len"}, 32'(busy_total - b0), 32'(18 * HP));
        check({tag, "_rx"}, 32'(spi_data_out), 32'(lb ? tx : sb));
        check({tag, "_frames"}, 32'(cs_falls - c0), 32'd1);
    endtask

    initial begin
        int r0, c0, z0, gap, n;
        logic [7:0] t, s;
        bit lb;

        rst = 1'b0;
        spi_ready_send = 1'b1;
        spi_data_in = 8'hFF;
        r0 = rises;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_busy", 32'(spi_busy), 32'd0);
            check("rst_cs_n", 32'(cs_n), 32'd1);
            check("rst_sclk", 32'(sclk), 32'd0);
            check("rst_mosi", 32'(mosi), 32'd0);
            check("rst_out", 32'(spi_data_out), 32'h00);
        end
        check("rst_no_rise", 32'(rises - r0), 32'd0);
        spi_ready_send = 1'b0;
        step();
        rst = 1'b1;
        step();

        xfer(8'hA5, 8'h00, 1'b1, "loop_a5");

        z0 = mosi_zero;
        xfer(8'hFF, 8'h3C, 1'b0, "slave_3c");
        check("ff_mosi_const", 32'(mosi_zero - z0), 32'd0);

        // Request held through busy fall: back-to-back frames, second latches new data.
        c0 = cs_falls;
        loopback = 1'b1;
        spi_data_in = 8'h3C;
        spi_ready_send = 1'b1;
        wait_busy(1'b1, 10, "b2b_busy1");
        spi_data_in = 8'h96;
        n = 0;
        while (cs_n !== 1'b1 && n < 40 * HP) begin step(); n++; end
        gap = 0;
        while (cs_n === 1'b1 && gap < 100) begin step(); gap++; end
        check("b2b_gap_ge", 32'(gap >= int'(HP + 1)), 32'd1);
        check("b2b_busy2", 32'(spi_busy), 32'd1);
        check("b2b_out1", 32'(spi_data_out), 32'h3C);
        spi_ready_send = 1'b0;
        wait_busy(1'b0, 40 * HP + 20, "b2b_fall2");
        check("b2b_out2", 32'(spi_data_out), 32'h96);
        check("b2b_frames", 32'(cs_falls - c0), 32'd2);
        repeat (20) step();
        check("b2b_no_extra", 32'(cs_falls - c0), 32'd2);

        // Request and data wiggle mid-transfer must be ignored.
        c0 = cs_falls;
        spi_data_in = 8'h81;
        spi_ready_send = 1'b1;
        wait_busy(1'b1, 10, "ign_busy");
        spi_ready_send = 1'b0;
        spi_data_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            spi_ready_send = ~spi_ready_send;
            step();
        end
        spi_ready_send = 1'b0;
        wait_busy(1'b0, 40 * HP + 20, "ign_fall");
        check("ign_mosi", 32'(mosi_hist[7:0]), 32'h81);
        check("ign_rx", 32'(spi_data_out), 32'h81);
        repeat (10) step();
        check("ign_frames", 32'(cs_falls - c0), 32'd1);

        // Reset after the third sclk rise aborts the frame and clears the output.
        r0 = rises;
        spi_data_in = 8'hC3;
        spi_ready_send = 1'b1;
        wait_busy(1'b1, 10, "abort_busy");
        spi_ready_send = 1'b0;
        n = 0;
        while (rises - r0 < 3 && n < 20 * HP) begin step(); n++; end
        check("abort_rises", 32'(rises - r0), 32'd3);
        rst = 1'b0;
        step();
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy0", 32'(spi_busy), 32'd0);
        check("abort_out", 32'(spi_data_out), 32'h00);
        rst = 1'b1;
        step();
        xfer(8'h5A, 8'h00, 1'b1, "post_abort");

        for (int i = 0; i < 8; i++) begin
            t  = 8'($urandom);
            s  = 8'($urandom);
            lb = 1'($urandom_range(1));
            xfer(t, s, lb, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
